// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-fed UART transmitter, idle-high line, LSB first, back-to-back frames.
// Optional parity bit is compiled in when UART_TX_PARITY_EN is defined.
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 1_152_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY_ODD = 0
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [DATA_BITS-1:0]        Din,
    input  logic                        Wr,
    output logic                        Full,
    output logic                        Empty,
    output logic [$clog2(FIFO_DEPTH):0] Level,
    output logic                        Busy,
    output logic                        Dout
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int BIT_W        = $clog2(DATA_BITS);
    localparam int PTR_W        = $clog2(FIFO_DEPTH);
    localparam int LVL_W        = PTR_W + 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);

    if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
        FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_config
        $error("uart_tx_fifo: illegal parameter combination");
    end

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [LVL_W-1:0]     level_n;
    logic [DATA_BITS-1:0] head;
    logic                 wr_acc;
    logic                 pop;

    state_t               state;
    state_t               state_n;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_n;
    logic [BIT_W-1:0]     bit_idx;
    logic [BIT_W-1:0]     bit_n;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] shreg_n;
    logic                 dout_n;
    logic                 busy_n;
    logic                 bit_done;
    logic                 load;

`ifdef UART_TX_PARITY_EN
    localparam logic PAR_POL = 1'(PARITY_ODD);
    logic par_q;
    logic par_n;
    assign par_n = load ? ((^head) ^ PAR_POL) : par_q;
`endif

    // Full is the registered flag, so a same-edge pop never opens room for a write.
    assign wr_acc   = Wr && !Full;
    assign head     = mem[rd_ptr];
    assign bit_done = (cnt == CNT_LAST);
    assign pop      = load;

    always_comb begin
        level_n = Level;
        if (wr_acc && !pop) begin
            level_n = Level + 1'b1;
        end else if (!wr_acc && pop) begin
            level_n = Level - 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            Level  <= '0;
            Full   <= 1'b0;
            Empty  <= 1'b1;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            Level <= level_n;
            Full  <= (level_n == LVL_FULL);
            Empty <= (level_n == '0);
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_acc) begin
            mem[wr_ptr] <= Din;
        end
    end

    // dout_n/busy_n carry the value the line takes in the state being entered.
    always_comb begin
        state_n = state;
        cnt_n   = bit_done ? '0 : cnt + 1'b1;
        bit_n   = bit_idx;
        shreg_n = shreg;
        dout_n  = Dout;
        busy_n  = Busy;
        load    = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_n  = '0;
                dout_n = 1'b1;
                busy_n = 1'b0;
                load   = !Empty;
            end
            S_START: begin
                if (bit_done) begin
                    state_n = S_DATA;
                    bit_n   = '0;
                    dout_n  = shreg[0];
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    if (bit_idx == DATA_LAST) begin
                        bit_n   = '0;
`ifdef UART_TX_PARITY_EN
                        state_n = S_PARITY;
                        dout_n  = par_q;
`else
                        state_n = S_STOP;
                        dout_n  = 1'b1;
`endif
                    end else begin
                        bit_n   = bit_idx + 1'b1;
                        shreg_n = shreg >> 1;
                        dout_n  = shreg[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_done) begin
                    state_n = S_STOP;
                    dout_n  = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (bit_done) begin
                    if (bit_idx == STOP_LAST) begin
                        bit_n = '0;
                        if (!Empty) begin
                            load = 1'b1;
                        end else begin
                            state_n = S_IDLE;
                            dout_n  = 1'b1;
                            busy_n  = 1'b0;
                        end
                    end else begin
                        bit_n = bit_idx + 1'b1;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
                dout_n  = 1'b1;
                busy_n  = 1'b0;
            end
        endcase
        if (load) begin
            state_n = S_START;
            cnt_n   = '0;
            shreg_n = head;
            dout_n  = 1'b0;
            busy_n  = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            Dout    <= 1'b1;
            Busy    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_n;
            shreg   <= shreg_n;
            Dout    <= dout_n;
            Busy    <= busy_n;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_n;
`endif
        end
    end

endmodule
